// File: rtl/mv_min_sel_pkg.sv
// Shared types and default parameters for the motion-vector decision stage.
package mv_min_sel_pkg;

    localparam int unsigned DEF_WORD_WIDTH = 8;
    localparam int unsigned DEF_BLK        = 16;
    localparam int unsigned DEF_SR         = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mv_min_sel_sad_cmp.sv
// Decides whether the current candidate replaces the running minimum.
module mv_min_sel_sad_cmp #(
    parameter int unsigned SAD_W = 16
) (
    input  logic [SAD_W-1:0] sad_in,
    input  logic [SAD_W-1:0] min_sad,
    input  logic             is_first,
    input  logic             is_zero_mv,
    output logic             take
);

    // First candidate always loads; otherwise strictly smaller, or equal at the zero vector
    always_comb begin
        take = is_first
            || (sad_in < min_sad)
            || (is_zero_mv && (sad_in == min_sad));
    end

endmodule

// File: rtl/mv_min_sel.sv
// Tracks the minimum SAD over a raster-ordered search window and emits the best MV.
module mv_min_sel
    import mv_min_sel_pkg::*;
#(
    parameter int unsigned WORD_WIDETH = DEF_WORD_WIDTH,
    parameter int unsigned BLK         = DEF_BLK,
    parameter int unsigned SR          = DEF_SR,
    parameter int unsigned SAD_W       = WORD_WIDETH + 2 * $clog2(BLK),
    parameter int unsigned MV_W        = $clog2(SR) + 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    block_start,
    input  logic                    sad_valid,
    input  logic [SAD_W-1:0]        sad_in,
    output logic                    busy,
    output logic                    mv_valid,
    output logic signed [MV_W-1:0]  mv_x,
    output logic signed [MV_W-1:0]  mv_y,
    output logic [SAD_W-1:0]        best_sad
);

    localparam int unsigned CNT_W = $clog2(2 * SR);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(2 * SR - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO_MV = CNT_W'(SR);

    state_t           state;
    state_t           state_next;

    logic [CNT_W-1:0] cx;
    logic [CNT_W-1:0] cy;
    logic [SAD_W-1:0] min_sad;
    logic [CNT_W-1:0] min_x;
    logic [CNT_W-1:0] min_y;

    logic             accept;
    logic             first;
    logic             last;
    logic [CNT_W-1:0] cur_x;
    logic [CNT_W-1:0] cur_y;
    logic             zero_mv;
    logic             take;
    logic [CNT_W-1:0] fin_x;
    logic [CNT_W-1:0] fin_y;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: block_start restarts from any state
    always_comb begin
        state_next = state;
        if (block_start) begin
            state_next = ST_SCAN;
        end else begin
            case (state)
                ST_IDLE: state_next = ST_IDLE;
                ST_SCAN: if (last) state_next = ST_DONE;
                ST_DONE: state_next = ST_IDLE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Decode of the accepted candidate: coordinates, first/last flags
    always_comb begin
        accept = 1'b0;
        first  = 1'b0;
        last   = 1'b0;
        cur_x  = cx;
        cur_y  = cy;
        if (block_start) begin
            accept = sad_valid;
            first  = 1'b1;
            cur_x  = '0;
            cur_y  = '0;
        end else if (state == ST_SCAN) begin
            accept = sad_valid;
            first  = (cx == '0) && (cy == '0);
            last   = sad_valid && (cx == CNT_MAX) && (cy == CNT_MAX);
        end
    end

    assign zero_mv = (cur_x == CNT_ZERO_MV) && (cur_y == CNT_ZERO_MV);

    mv_min_sel_sad_cmp #(
        .SAD_W (SAD_W)
    ) u_sad_cmp (
        .sad_in     (sad_in),
        .min_sad    (min_sad),
        .is_first   (first),
        .is_zero_mv (zero_mv),
        .take       (take)
    );

    // Winner including the candidate sampled this cycle
    assign fin_x = take ? cur_x : min_x;
    assign fin_y = take ? cur_y : min_y;

    // Counters, running minimum and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            cx       <= '0;
            cy       <= '0;
            min_sad  <= '0;
            min_x    <= '0;
            min_y    <= '0;
            busy     <= 1'b0;
            mv_valid <= 1'b0;
            mv_x     <= '0;
            mv_y     <= '0;
            best_sad <= '0;
        end else begin
            busy     <= (state_next == ST_SCAN);
            mv_valid <= (state_next == ST_DONE);

            if (block_start) begin
                cx <= accept ? CNT_W'(1) : '0;
                cy <= '0;
            end else if (last) begin
                cx <= '0;
                cy <= '0;
            end else if (accept) begin
                if (cx == CNT_MAX) begin
                    cx <= '0;
                    cy <= cy + CNT_W'(1);
                end else begin
                    cx <= cx + CNT_W'(1);
                end
            end

            if (accept && take) begin
                min_sad <= sad_in;
                min_x   <= cur_x;
                min_y   <= cur_y;
            end

            if (last) begin
                best_sad <= take ? sad_in : min_sad;
                mv_x     <= MV_W'(fin_x) - MV_W'(SR);
                mv_y     <= MV_W'(fin_y) - MV_W'(SR);
            end
        end
    end

endmodule

// File: tb/tb_mv_min_sel.sv
// Scoreboard bench for mv_min_sel: expected results queued at the last sample, checked on mv_valid.
module tb_mv_min_sel;

    localparam int unsigned SAD_W = 16;
    localparam int unsigned MV_W  = 5;
    localparam int          NCAND = 256;
    localparam int          EDGE  = 16;
    localparam int          SRV   = 8;

    typedef struct {
        logic [MV_W-1:0]  x;
        logic [MV_W-1:0]  y;
        logic [SAD_W-1:0] sad;
        int               cyc;
    } exp_t;

    logic                   clk;
    logic                   rst;
    logic                   block_start;
    logic                   sad_valid;
    logic [SAD_W-1:0]       sad_in;
    logic                   busy;
    logic                   mv_valid;
    logic signed [MV_W-1:0] mv_x;
    logic signed [MV_W-1:0] mv_y;
    logic [SAD_W-1:0]       best_sad;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t q[$];
    exp_t last_res;
    logic [SAD_W-1:0] sads [NCAND];

    mv_min_sel dut (
        .clk         (clk),
        .rst         (rst),
        .block_start (block_start),
        .sad_valid   (sad_valid),
        .sad_in      (sad_in),
        .busy        (busy),
        .mv_valid    (mv_valid),
        .mv_x        (mv_x),
        .mv_y        (mv_y),
        .best_sad    (best_sad)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference search: raster order, strict less-than, equality wins only at (0,0)
    function automatic int best_idx();
        int b = 0;
        for (int i = 1; i < NCAND; i++) begin
            if (sads[i] < sads[b] || (i == SRV * EDGE + SRV && sads[i] == sads[b]))
                b = i;
        end
        return b;
    endfunction

    function automatic exp_t make_exp(input int vcyc);
        exp_t e;
        int   b = best_idx();
        e.x   = MV_W'((b % EDGE) - SRV);
        e.y   = MV_W'((b / EDGE) - SRV);
        e.sad = sads[b];
        e.cyc = vcyc;
        return e;
    endfunction

    // Output monitor: every mv_valid must match the head of the scoreboard at the right cycle
    always @(posedge clk) begin
        exp_t e;
        cyc++;
        #1;
        if (mv_valid === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_mv_valid cyc=%0d mv=(%0d,%0d) sad=%0d, required no pulse",
                         cyc, mv_x, mv_y, best_sad);
            end else begin
                e = q.pop_front();
                if (mv_x !== e.x || mv_y !== e.y || best_sad !== e.sad || cyc != e.cyc || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL result got mv=(%0d,%0d) sad=%0d cyc=%0d busy=%b, required mv=(%0d,%0d) sad=%0d cyc=%0d busy=0",
                             mv_x, mv_y, best_sad, cyc, busy,
                             $signed(e.x), $signed(e.y), e.sad, e.cyc);
                end
                last_res = e;
            end
        end
    end

    // Drives a scan of n candidates with random gaps; queues an expectation for full scans
    task automatic scan(input int n, input bit coincident, input int gap_pct);
        int first_i = coincident ? 1 : 0;
        @(negedge clk);
        block_start = 1'b1;
        sad_valid   = coincident;
        sad_in      = sads[0];
        for (int i = first_i; i < n; i++) begin
            @(negedge clk);
            block_start = 1'b0;
            if (i == first_i) begin
                checks++;
                if (busy !== 1'b1 || mv_x !== last_res.x || mv_y !== last_res.y || best_sad !== last_res.sad) begin
                    errors++;
                    $display("FAIL start_state busy=%b mv=(%0d,%0d) sad=%0d, required busy=1 mv=(%0d,%0d) sad=%0d",
                             busy, mv_x, mv_y, best_sad,
                             $signed(last_res.x), $signed(last_res.y), last_res.sad);
                end
            end
            while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                sad_valid = 1'b0;
                @(negedge clk);
            end
            sad_valid = 1'b1;
            sad_in    = sads[i];
            if (i == NCAND - 1) q.push_back(make_exp(cyc + 1));
        end
        @(negedge clk);
        sad_valid   = 1'b0;
        block_start = 1'b0;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 20 && q.size() != 0; k++) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL timeout pending=%0d, required 0", q.size());
            q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (busy !== 1'b0 || mv_valid !== 1'b0 || mv_x !== '0 || mv_y !== '0 || best_sad !== '0) begin
            errors++;
            $display("FAIL %s busy=%b mv_valid=%b mv=(%0d,%0d) sad=%0d, required all 0",
                     name, busy, mv_valid, mv_x, mv_y, best_sad);
        end
        last_res = '{x: '0, y: '0, sad: '0, cyc: 0};
    endtask

    task automatic test_reset();
        rst = 1'b1; block_start = 1'b0; sad_valid = 1'b0; sad_in = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        // sad_valid while idle must not produce anything
        sad_valid = 1'b1; sad_in = 16'd5;
        repeat (5) @(negedge clk);
        sad_valid = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_busy got %b, required 0", busy);
        end
    endtask

    task automatic test_monotone();
        for (int i = 0; i < NCAND; i++) sads[i] = SAD_W'(1000 - i);
        scan(NCAND, 1'b0, 0);
        wait_drain();
    endtask

    task automatic test_tie_zero_bias();
        for (int i = 0; i < NCAND; i++) sads[i] = 16'd50;
        scan(NCAND, 1'b0, 0);
        wait_drain();
        sads[SRV * EDGE + SRV] = 16'd51;
        scan(NCAND, 1'b0, 10);
        wait_drain();
    endtask

    task automatic test_gaps_coincident();
        for (int i = 0; i < NCAND; i++) sads[i] = SAD_W'($urandom_range(1000, 1));
        sads[0] = 16'd0;
        scan(NCAND, 1'b1, 30);
        wait_drain();
    endtask

    task automatic test_restart();
        for (int i = 0; i < NCAND; i++) sads[i] = SAD_W'($urandom_range(2, 0));
        scan(100, 1'b0, 0);
        for (int i = 0; i < NCAND; i++) sads[i] = SAD_W'($urandom_range(1000, 10));
        sads[3 * EDGE + 10] = 16'd3;
        scan(NCAND, 1'b0, 5);
        wait_drain();
    endtask

    task automatic test_reset_mid_scan();
        for (int i = 0; i < NCAND; i++) sads[i] = SAD_W'($urandom_range(1000, 0));
        scan(40, 1'b0, 0);
        rst = 1'b1;
        @(negedge clk);
        check_zero("reset_mid_scan");
        rst = 1'b0;
        sad_valid = 1'b1; sad_in = 16'd1;
        repeat (300) @(negedge clk);
        sad_valid = 1'b0;
        check_zero("idle_after_reset");
        scan(NCAND, 1'b0, 5);
        wait_drain();
    endtask

    task automatic test_max_value();
        for (int i = 0; i < NCAND; i++) sads[i] = 16'hFFFF;
        scan(NCAND, 1'b0, 0);
        wait_drain();
    endtask

    initial begin
        last_res = '{x: '0, y: '0, sad: '0, cyc: 0};
        test_reset();
        test_monotone();
        test_tie_zero_bias();
        test_gaps_coincident();
        test_restart();
        test_reset_mid_scan();
        test_max_value();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
